serial_word_capture: RTL and testbench
======================================

# serial_word_capture

Downstream consumer of the single-bit registered stream produced by the positive-edge flip-flop stage. It samples that `Q` stream on `clk`, frames it with start/stop bits, and assembles WIDTH-bit words LSB-first. Completed words are presented on a valid/ready output port. Framing and overrun failures are flagged with one-cycle pulses.

## Interface
- `WIDTH`: default 8. Data bits per frame; legal range 2..32.
- `clk`  in  1: single clock; all state changes on the rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `ser_in`  in  1: registered serial bit from the upstream flip-flop stage.
- `ser_en`  in  1: sample strobe; `ser_in` is consumed only on edges where `ser_en`=1.
- `out_ready`  in  1: downstream accepts the word when `out_valid`=1 and `out_ready`=1.
- `out_data`  out  WIDTH: assembled word; stable while `out_valid`=1.
- `out_valid`  out  1: word available.
- `frame_err`  out  1: one-cycle pulse on a bad stop bit (or bad parity, see Configuration).
- `overrun`  out  1: one-cycle pulse when a completed word is dropped.
- `busy`  out  1: high in any state other than IDLE.

## Operation
- FSM states: IDLE, DATA, PARITY (exists only with the macro), STOP.
- IDLE: on a sampled `ser_in`=0 (start bit), clear `bit_cnt` and go to DATA. A sampled 1 keeps the FSM in IDLE.
- DATA: each sample shifts into bit position `bit_cnt`, LSB first, and increments `bit_cnt`. After sample WIDTH-1, go to STOP (or PARITY).
- `bit_cnt` is $clog2(WIDTH) bits wide. It never wraps inside a frame and is cleared on every start bit.
- STOP with sampled 1: the frame completes and the FSM returns to IDLE.
- STOP with sampled 0: pulse `frame_err`, discard the word, return to IDLE. The 0 is not treated as a new start bit.
- Word completion with `out_valid`=0: load `out_data`, set `out_valid`.
- Word completion with `out_valid`=1 and `out_ready`=1 on the same edge: the old word is accepted, the new word is loaded, `out_valid` stays 1, and `overrun` stays 0.
- Word completion with `out_valid`=1 and `out_ready`=0: the new word is dropped, `overrun` pulses, and `out_data` keeps the old word.
- Handshake: `out_valid` stays high until accepted. When `out_valid`=1, `out_data` does not change except through the simultaneous-accept case above.
- `ser_en`=0: FSM, counter and shift register hold. The output handshake still operates.

## Timing
- Reset values: `out_data`=0, `out_valid`=0, `frame_err`=0, `overrun`=0, `busy`=0, FSM=IDLE, `bit_cnt`=0, shift register=0.
- Reset asserted mid-frame: the partial word is lost and everything returns to the values above immediately (asynchronous).
- Latency: `out_valid` rises on the same edge that samples the stop bit. A frame takes WIDTH+2 enabled samples (WIDTH+3 with parity).
- Back-to-back frames: a start bit may be sampled on the enabled edge right after the stop bit.
- `frame_err` and `overrun` are registered pulses, exactly one cycle wide.
- `busy` is registered: high from the edge that samples the start bit through the edge that samples the stop bit.

## Configuration
- `SERIAL_CAPTURE_PARITY_EN` defined:
  - An even-parity bit is sampled in the PARITY state between DATA and STOP.
  - A parity mismatch raises `frame_err` on the stop-bit edge, even when the stop bit is good, and the word is discarded.
- `SERIAL_CAPTURE_PARITY_EN` undefined:
  - The PARITY state and the parity register are absent.
  - DATA goes directly to STOP.

## Structure
- Shared package `serial_capture_pkg`:
  - FSM state enum (IDLE=0, DATA=1, PARITY=2, STOP=3); encoding fixed regardless of macro.
  - `SC_WIDTH_MAX`=32.
- One sub-module `sc_shift_reg`: WIDTH-bit shift register with enable and async active-low clear, LSB-first fill.

## Test plan
- WIDTH=8, frame 0,1,0,1,0,0,1,0,1 with `ser_en`=1 and `out_ready`=1 -> `out_data`=8'h4A, `out_valid` high one cycle, no error pulses.
- Same frame with stop bit 0 -> `frame_err` pulses once, `out_valid` stays 0, FSM back in IDLE.
- Two frames 8'hA5 then 8'h3C with `out_ready`=0 -> `out_data`=8'hA5 held, `overrun` pulses once at the second stop bit.
- 8'hA5 held, then 8'h3C completes on the same edge `out_ready`=1 -> `out_data`=8'h3C, `out_valid`=1, `overrun`=0.
- `ser_en` toggled 0/1 every cycle during frame 8'hFF -> `out_data`=8'hFF after 10 enabled samples.
- `rst_n` asserted after 4 data bits -> all outputs 0 immediately; next clean frame 8'h01 captured correctly.

Source files
------------

// File: rtl/serial_capture_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : serial_capture_pkg                                         |
// | Description : Shared types and constants for the serial word capture     |
// |               block: FSM state encoding and the maximum word width.      |
// |               The state encoding is fixed whether or not the optional    |
// |               SERIAL_CAPTURE_PARITY_EN feature is compiled in.           |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
package serial_capture_pkg;

   localparam int SC_WIDTH_MAX = 32;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DATA   = 2'd1,
      PARITY = 2'd2,
      STOP   = 2'd3
   } sc_state_t;

endpackage : serial_capture_pkg
`default_nettype wire

// File: rtl/sc_shift_reg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : sc_shift_reg                                               |
// | Description : WIDTH-bit shift register, LSB-first fill. New bits enter   |
// |               at the MSB and move right, so after WIDTH enabled shifts   |
// |               the first bit received sits in bit 0.                      |
// | Ports       : clk   - clock                                              |
// |               rst_n - asynchronous active-low clear                      |
// |               en    - shift enable                                       |
// |               din   - serial data in                                     |
// |               q     - parallel word                                      |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module sc_shift_reg #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic             din,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] r_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_q <= '0;
      end else if (en) begin
         r_q <= {din, r_q[WIDTH-1:1]};
      end
   end

   assign q = r_q;

endmodule : sc_shift_reg
`default_nettype wire

// File: rtl/serial_word_capture.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : serial_word_capture                                        |
// | Description : Samples a registered serial stream on enabled edges,       |
// |               frames it with a start bit (0) and stop bit (1), and       |
// |               assembles WIDTH-bit words LSB-first onto a valid/ready     |
// |               port. Bad stop bits pulse frame_err; words completed while |
// |               the output is stalled are dropped and pulse overrun.       |
// | Ports       : clk, rst_n (async active-low)                              |
// |               ser_in, ser_en          - serial bit and sample strobe     |
// |               out_ready               - downstream accept                |
// |               out_data, out_valid     - assembled word and valid         |
// |               frame_err, overrun      - one-cycle error pulses           |
// |               busy                    - frame in progress                |
// | Options     : SERIAL_CAPTURE_PARITY_EN - adds an even-parity bit between |
// |               the data bits and the stop bit; a mismatch is reported as  |
// |               frame_err on the stop-bit edge and the word is discarded.  |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module serial_word_capture
   import serial_capture_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             ser_in,
   input  logic             ser_en,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic             out_valid,
   output logic             frame_err,
   output logic             overrun,
   output logic             busy
);

   localparam int                c_CNT_W = $clog2(WIDTH);
   localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(WIDTH - 1);

   sc_state_t          r_state;
   sc_state_t          w_next;
   logic [c_CNT_W-1:0] r_bit_cnt;
   logic [WIDTH-1:0]   w_word;
   logic               w_shift_en;
   logic               w_start;
   logic               w_stop_edge;
   logic               w_par_bad;
   logic               w_complete;
   logic               w_bad_frame;

   logic [WIDTH-1:0]   r_out_data;
   logic               r_out_valid;
   logic               r_frame_err;
   logic               r_overrun;
   logic               r_busy;

   // ---------------------------------------------------------------- state
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // ----------------------------------------------------------- next state
   always_comb begin
      w_next = r_state;
      if (ser_en) begin
         case (r_state)
            IDLE: if (!ser_in) w_next = DATA;
            DATA: begin
               if (r_bit_cnt == c_LAST) begin
`ifdef SERIAL_CAPTURE_PARITY_EN
                  w_next = PARITY;
`else
                  w_next = STOP;
`endif
               end
            end
`ifdef SERIAL_CAPTURE_PARITY_EN
            PARITY: w_next = STOP;
`endif
            // A 0 in STOP is a framing error, not a new start bit.
            STOP:    w_next = IDLE;
            default: w_next = IDLE;
         endcase
      end
   end

   // ------------------------------------------------------ decoded strobes
   always_comb begin
      w_shift_en  = ser_en && (r_state == DATA);
      w_start     = ser_en && (r_state == IDLE) && !ser_in;
      w_stop_edge = ser_en && (r_state == STOP);
      w_complete  = w_stop_edge && ser_in && !w_par_bad;
      w_bad_frame = w_stop_edge && (!ser_in || w_par_bad);
   end

   // ------------------------------------------------------------- bit count
   // Holds at WIDTH-1 on the last data bit so it never wraps mid-frame.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_bit_cnt <= '0;
      end else if (w_start) begin
         r_bit_cnt <= '0;
      end else if (w_shift_en && (r_bit_cnt != c_LAST)) begin
         r_bit_cnt <= r_bit_cnt + 1'b1;
      end
   end

   // ---------------------------------------------------------------- parity
`ifdef SERIAL_CAPTURE_PARITY_EN
   logic r_par_acc;
   logic r_par_err;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_par_acc <= 1'b0;
         r_par_err <= 1'b0;
      end else if (w_start) begin
         r_par_acc <= 1'b0;
         r_par_err <= 1'b0;
      end else if (w_shift_en) begin
         r_par_acc <= r_par_acc ^ ser_in;
      end else if (ser_en && (r_state == PARITY)) begin
         // Even parity: data bits plus parity bit must XOR to zero.
         r_par_err <= r_par_acc ^ ser_in;
      end
   end

   assign w_par_bad = r_par_err;
`else
   assign w_par_bad = 1'b0;
`endif

   // ---------------------------------------------------------- shift register
   sc_shift_reg #(
      .WIDTH (WIDTH)
   ) u_shift (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (w_shift_en),
      .din   (ser_in),
      .q     (w_word)
   );

   // ------------------------------------------------------- output handshake
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_out_data  <= '0;
         r_out_valid <= 1'b0;
         r_frame_err <= 1'b0;
         r_overrun   <= 1'b0;
         r_busy      <= 1'b0;
      end else begin
         r_frame_err <= w_bad_frame;
         r_overrun   <= w_complete && r_out_valid && !out_ready;
         r_busy      <= (w_next != IDLE);
         // A word may be loaded when the slot is empty or being emptied
         // on this same edge; otherwise the held word has priority.
         if (w_complete && (!r_out_valid || out_ready)) begin
            r_out_data  <= w_word;
            r_out_valid <= 1'b1;
         end else if (r_out_valid && out_ready) begin
            r_out_valid <= 1'b0;
         end
      end
   end

   assign out_data  = r_out_data;
   assign out_valid = r_out_valid;
   assign frame_err = r_frame_err;
   assign overrun   = r_overrun;
   assign busy      = r_busy;

endmodule : serial_word_capture
`default_nettype wire

// File: tb/tb_serial_word_capture.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_serial_word_capture                                     |
// | Description : Self-checking bench for serial_word_capture (WIDTH=8).     |
// |               Stimulus pushes expected words into a queue; a monitor     |
// |               pops and compares on every accepted output word and counts |
// |               error pulses. Directed checks cover reset, stall, overrun, |
// |               simultaneous accept, strobe gating and mid-frame reset.    |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_serial_word_capture;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         ser_in;
   logic         ser_en;
   logic         out_ready;
   logic [W-1:0] out_data;
   logic         out_valid;
   logic         frame_err;
   logic         overrun;
   logic         busy;

   serial_word_capture #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .ser_in    (ser_in),
      .ser_en    (ser_en),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_valid (out_valid),
      .frame_err (frame_err),
      .overrun   (overrun),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   int           checks       = 0;
   int           errors       = 0;
   int           ferr_seen    = 0;
   int           ovr_seen     = 0;
   int           valid_cycles = 0;
   logic [W-1:0] exp_q[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Monitor: compares every word the downstream side accepts.
   always @(negedge clk) begin
      if (rst_n) begin
         if (frame_err) ferr_seen++;
         if (overrun)   ovr_seen++;
         if (out_valid) valid_cycles++;
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_word: got 0x%0h expected none", out_data);
            end else begin
               check("word", 32'(out_data), 32'(exp_q.pop_front()));
            end
         end
      end
   end

   task automatic sync();
      @(posedge clk);
      #1;
   endtask

   task automatic send_bit(input logic b, input logic en);
      ser_in = b;
      ser_en = en;
      sync();
   endtask

   // Start bit, LSB-first data, optional parity bit.
   task automatic send_head(input logic [W-1:0] d);
      send_bit(1'b0, 1'b1);
      for (int i = 0; i < W; i++) send_bit(d[i], 1'b1);
`ifdef SERIAL_CAPTURE_PARITY_EN
      send_bit(^d, 1'b1);
`endif
   endtask

   task automatic send_frame(input logic [W-1:0] d, input logic stop, input logic push);
      if (push) exp_q.push_back(d);
      send_head(d);
      send_bit(stop, 1'b1);
      ser_in = 1'b1;
   endtask

   int v0;

   initial begin
      rst_n     = 1'b0;
      ser_in    = 1'b1;
      ser_en    = 1'b0;
      out_ready = 1'b1;
      repeat (2) @(negedge clk);
      check("rst_out_data",  32'(out_data), 32'h0);
      check("rst_out_valid", 32'(out_valid), 32'h0);
      check("rst_frame_err", 32'(frame_err), 32'h0);
      check("rst_overrun",   32'(overrun), 32'h0);
      check("rst_busy",      32'(busy), 32'h0);
      sync();
      rst_n = 1'b1;
      sync();

      // 1: clean frame 0x4A with downstream ready
      v0 = valid_cycles;
      send_frame(8'h4A, 1'b1, 1'b1);
      repeat (3) @(negedge clk);
      check("t1_valid_cycles", 32'(valid_cycles - v0), 32'd1);
      check("t1_no_ferr", 32'(ferr_seen), 32'd0);
      check("t1_no_ovr",  32'(ovr_seen), 32'd0);
      sync();

      // 2: same frame, bad stop bit
      send_frame(8'h4A, 1'b0, 1'b0);
      @(negedge clk);
      check("t2_frame_err", 32'(frame_err), 32'h1);
      check("t2_out_valid", 32'(out_valid), 32'h0);
      check("t2_busy_idle", 32'(busy), 32'h0);
      @(negedge clk);
      check("t2_ferr_1cyc", 32'(frame_err), 32'h0);
      sync();

      // 3: two frames while stalled, second dropped
      out_ready = 1'b0;
      send_frame(8'hA5, 1'b1, 1'b1);
      send_frame(8'h3C, 1'b1, 1'b0);
      @(negedge clk);
      check("t3_overrun",   32'(overrun), 32'h1);
      check("t3_held_data", 32'(out_data), 32'hA5);
      check("t3_valid",     32'(out_valid), 32'h1);
      @(negedge clk);
      check("t3_ovr_1cyc",  32'(overrun), 32'h0);
      sync();

      // 4: 0x3C completes on the edge 0xA5 is accepted
      exp_q.push_back(8'h3C);
      send_head(8'h3C);
      out_ready = 1'b1;
      send_bit(1'b1, 1'b1);
      @(negedge clk);
      check("t4_valid",   32'(out_valid), 32'h1);
      check("t4_data",    32'(out_data), 32'h3C);
      check("t4_overrun", 32'(overrun), 32'h0);
      sync();

      // 5: strobe toggled every cycle; junk on disabled cycles must be ignored
      exp_q.push_back(8'hFF);
      send_bit(1'b0, 1'b0);
      send_bit(1'b0, 1'b1);
      check("t5_busy", 32'(busy), 32'h1);
      for (int i = 0; i < W; i++) begin
         send_bit(1'b0, 1'b0);
         send_bit(1'b1, 1'b1);
      end
`ifdef SERIAL_CAPTURE_PARITY_EN
      send_bit(1'b1, 1'b0);
      send_bit(1'b0, 1'b1);
`endif
      send_bit(1'b0, 1'b0);
      send_bit(1'b1, 1'b1);
      @(negedge clk);
      check("t5_valid", 32'(out_valid), 32'h1);
      check("t5_data",  32'(out_data), 32'hFF);
      sync();
      sync();

      // 6: pending word plus partial frame, then asynchronous reset
      out_ready = 1'b0;
      send_frame(8'h77, 1'b1, 1'b1);
      send_bit(1'b0, 1'b1);
      send_bit(1'b1, 1'b1);
      send_bit(1'b0, 1'b1);
      send_bit(1'b1, 1'b1);
      send_bit(1'b1, 1'b1);
      #2;
      rst_n = 1'b0;
      #1;
      check("t6_rst_data",  32'(out_data), 32'h0);
      check("t6_rst_valid", 32'(out_valid), 32'h0);
      check("t6_rst_busy",  32'(busy), 32'h0);
      check("t6_rst_ferr",  32'(frame_err), 32'h0);
      check("t6_rst_ovr",   32'(overrun), 32'h0);
      exp_q.delete();
      ser_in = 1'b1;
      sync();
      rst_n     = 1'b1;
      out_ready = 1'b1;
      sync();
      send_frame(8'h01, 1'b1, 1'b1);

      // Drain with a bounded wait
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (exp_q.size() == 0) break;
      end
      @(negedge clk);
      check("queue_drained", 32'(exp_q.size()), 32'd0);
      check("total_ferr",    32'(ferr_seen), 32'd1);
      check("total_ovr",     32'(ovr_seen), 32'd1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule : tb_serial_word_capture
`default_nettype wire
